// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ASR  = 3'b101,
    MODE_RSV6 = 3'b110,
    MODE_RSV7 = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Left-moving modes expose the MSB on the serial output; everything else the LSB.
  function automatic logic sout_from_msb(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_ROL);
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational next-value datapath shared by single-step and burst operation.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             sin,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode_t'(mode))
      MODE_SHL: next_q = {q[WIDTH-2:0], sin};
      MODE_SHR: next_q = {sin, q[WIDTH-1:1]};
      MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
      MODE_ASR: next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, single-step modes and counted bursts
// driven by an IDLE/RUN/DONE controller.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       cap_mode;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    start_cnt;
  logic [2:0]       eff_mode;
  logic [WIDTH-1:0] next_q;

  assign start_cnt = (nshift > CW'(WIDTH)) ? CW'(WIDTH) : nshift;
  assign eff_mode  = (state == ST_IDLE) ? mode : cap_mode;
  assign sout      = sout_from_msb(eff_mode) ? q[WIDTH-1] : q[0];

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .q      (q),
    .sin    (sin),
    .mode   (eff_mode),
    .next_q (next_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      q        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cap_mode <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            q <= pdata;
          end else if (start) begin
            cap_mode <= mode;
            cnt      <= start_cnt;
            if (start_cnt == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end else begin
            q <= next_q;
          end
        end
        ST_RUN: begin
          // cnt holds shifts still to apply, so busy drops on the edge of the last one
          q   <= next_q;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] pdata;
  logic [2:0]       mode;
  logic             sin;
  logic             start;
  logic [CW-1:0]    nshift;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .pdata  (pdata),
    .mode   (mode),
    .sin    (sin),
    .start  (start),
    .nshift (nshift),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 64'(q), 64'(eq));
    chk({tag, ".busy"}, 64'(busy), 64'(eb));
    chk({tag, ".done"}, 64'(done), 64'(ed));
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; pdata = 8'hAA; mode = 3'b000;
    sin = 1'b0; start = 1'b1; nshift = 4'd3;
    #2;
    tick();
    chk_state("reset", 8'h00, 1'b0, 1'b0);

    // load wins over mode
    reset = 1'b0; load = 1'b1; start = 1'b0; pdata = 8'hCC; mode = 3'b001;
    tick();
    chk_state("load_cc", 8'hCC, 1'b0, 1'b0);

    pdata = 8'hAA; tick();
    load = 1'b0; mode = 3'b001; sin = 1'b1;
    #1 chk("sout_shl_msb", 64'(sout), 64'd1);
    tick();
    chk("shl_aa", 64'(q), 64'h55);
    mode = 3'b100; sin = 1'b0;
    #1 chk("sout_ror_lsb", 64'(sout), 64'd1);
    tick();
    chk("ror_55", 64'(q), 64'hAA);

    load = 1'b1; pdata = 8'h90; tick();
    load = 1'b0; mode = 3'b101; tick();
    chk("asr_90", 64'(q), 64'hC8);
    mode = 3'b010; sin = 1'b0; tick();
    chk("shr_c8", 64'(q), 64'h64);
    mode = 3'b010; sin = 1'b1; tick();
    chk("shr_sin1", 64'(q), 64'hB2);
    mode = 3'b000; tick();
    chk("hold_000", 64'(q), 64'hB2);
    mode = 3'b111; tick();
    chk("hold_111", 64'(q), 64'hB2);

    // rotate-left burst of 3 on 81 with load/mode noise during RUN and DONE
    load = 1'b1; pdata = 8'h81; mode = 3'b000; tick();
    load = 1'b0; start = 1'b1; mode = 3'b011; nshift = 4'd3; tick();
    chk_state("b3_start", 8'h81, 1'b1, 1'b0);
    start = 1'b0; load = 1'b1; pdata = 8'hFF; mode = 3'b010;
    #1 chk("b3_sout_cap", 64'(sout), 64'd1);
    tick(); chk_state("b3_s1", 8'h03, 1'b1, 1'b0);
    tick(); chk_state("b3_s2", 8'h06, 1'b1, 1'b0);
    tick(); chk_state("b3_s3", 8'h0C, 1'b0, 1'b1);
    tick(); chk_state("b3_idle", 8'h0C, 1'b0, 1'b0);
    load = 1'b0; mode = 3'b000;

    // zero-length burst
    start = 1'b1; mode = 3'b001; nshift = 4'd0; tick();
    chk_state("b0_start", 8'h0C, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000; tick();
    chk_state("b0_idle", 8'h0C, 1'b0, 1'b0);

    // clamped burst: 12 requested, 8 rotates
    load = 1'b1; pdata = 8'h5A; tick();
    load = 1'b0; start = 1'b1; mode = 3'b011; nshift = 4'd12; tick();
    chk_state("b12_start", 8'h5A, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("b12_busy", 64'(busy), 64'd1);
    end
    tick(); chk_state("b12_end", 8'h5A, 1'b0, 1'b1);
    tick(); chk_state("b12_idle", 8'h5A, 1'b0, 1'b0);

    // hold-mode burst keeps q but runs the timing
    start = 1'b1; mode = 3'b110; nshift = 4'd2; tick();
    chk_state("bh_start", 8'h5A, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b001; sin = 1'b1;
    tick(); chk_state("bh_s1", 8'h5A, 1'b1, 1'b0);
    tick(); chk_state("bh_s2", 8'h5A, 1'b0, 1'b1);
    tick();

    // shift-left burst: sin still feeds the captured mode
    start = 1'b1; mode = 3'b001; nshift = 4'd2; sin = 1'b1; tick();
    start = 1'b0; mode = 3'b100;
    tick(); chk("bsl_s1", 64'(q), 64'hB5);
    sin = 1'b1;
    tick(); chk_state("bsl_s2", 8'h6B, 1'b0, 1'b1);
    tick();

    // reset aborts a 5-cycle burst in its 2nd RUN cycle
    load = 1'b1; pdata = 8'h0F; sin = 1'b0; tick();
    load = 1'b0; start = 1'b1; mode = 3'b001; nshift = 4'd5; tick();
    chk_state("ab_start", 8'h0F, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_state("ab_s1", 8'h1E, 1'b1, 1'b0);
    reset = 1'b1; tick();
    chk_state("ab_reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0; mode = 3'b000; tick();
    chk_state("ab_after", 8'h00, 1'b0, 1'b0);
    start = 1'b1; nshift = 4'd1; tick();
    chk_state("ab_restart", 8'h00, 1'b1, 1'b0);
    start = 1'b0; tick();
    chk_state("ab_redone", 8'h00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
